// File: rtl/mips_irq_pkg.sv
// Shared types and constants for the MIPS v1 interrupt sequencer:
// FSM states, cause codes and status-word bit positions.
package mips_irq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_FLUSH,
    ST_REDIRECT,
    ST_HANDLER,
    ST_RETURN
  } state_t;

  localparam logic [2:0] CAUSE_IRQ0 = 3'd0;
  localparam logic [2:0] CAUSE_IRQ1 = 3'd1;
  localparam logic [2:0] CAUSE_IRQ2 = 3'd2;
  localparam logic [2:0] CAUSE_IRQ3 = 3'd3;
  localparam logic [2:0] CAUSE_TRAP = 3'd4;

  localparam int IRQ_LSB   = 8;
  localparam int TRAP_BIT  = 15;
  localparam int VEC_SHIFT = 4;
  localparam int NUM_IRQ   = 4;
  localparam int NUM_REQ   = NUM_IRQ + 1;

  // Status-word bit that a given cause clears once it is serviced.
  function automatic int cause_bit(input logic [2:0] cause);
    return (cause == CAUSE_TRAP) ? TRAP_BIT : IRQ_LSB + int'(cause);
  endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: trap (bit 4) wins, then irq3 down to irq0.
module irq_priority_encoder
  import mips_irq_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  output logic               o_valid,
  output logic [2:0]         o_cause
);

  always_comb begin
    o_valid = |i_req;
    o_cause = CAUSE_IRQ0;
    if (i_req[4])      o_cause = CAUSE_TRAP;
    else if (i_req[3]) o_cause = CAUSE_IRQ3;
    else if (i_req[2]) o_cause = CAUSE_IRQ2;
    else if (i_req[1]) o_cause = CAUSE_IRQ1;
    else               o_cause = CAUSE_IRQ0;
  end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt sequencer: arbitrates status-register requests, waits for an
// instruction boundary, flushes/redirects to the handler and returns on eret.
module irq_sequencer
  import mips_irq_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] VECTOR_BASE = DATA_WIDTH'(32'h0000_0080)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_status,
  input  logic [3:0]            i_mask,
  input  logic                  i_ie,
  input  logic                  i_commit,
  input  logic [DATA_WIDTH-1:0] i_next_pc,
  input  logic                  i_eret,
  output logic                  o_flush,
  output logic                  o_redirect,
  output logic [DATA_WIDTH-1:0] o_redirect_pc,
  output logic [DATA_WIDTH-1:0] o_epc,
  output logic [2:0]            o_cause,
  output logic                  o_in_handler,
  output logic                  o_ic_we,
  output logic [DATA_WIDTH-1:0] o_ic_data
);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [2:0]              r_cause;
  logic [DATA_WIDTH-1:0]   r_epc;
  logic [NUM_REQ-1:0]      w_req;
  logic                    w_req_valid;
  logic [2:0]              w_req_cause;
  logic                    w_armed_req;
  logic [DATA_WIDTH-1:0]   w_vector;
  logic [15:0]             w_status_clr;

  // The trap bypasses both the per-line mask and the global enable.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_req
      assign w_req[gi] = i_status[IRQ_LSB + gi] & i_mask[gi] & i_ie;
    end
  endgenerate
  assign w_req[NUM_REQ-1] = i_status[TRAP_BIT];

  irq_priority_encoder u_prio (
    .i_req   (w_req),
    .o_valid (w_req_valid),
    .o_cause (w_req_cause)
  );

  assign w_armed_req  = w_req[r_cause];
  assign w_vector     = VECTOR_BASE + (DATA_WIDTH'(r_cause) << VEC_SHIFT);
  assign w_status_clr = i_status[15:0] & ~(16'h0001 << cause_bit(r_cause));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_req_valid) w_state_next = ST_ARM;
      ST_ARM: begin
        if (!w_armed_req)  w_state_next = ST_IDLE;
        else if (i_commit) w_state_next = ST_FLUSH;
      end
      ST_FLUSH:    w_state_next = ST_REDIRECT;
      ST_REDIRECT: w_state_next = ST_HANDLER;
      ST_HANDLER:  if (i_eret) w_state_next = ST_RETURN;
      ST_RETURN:   w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  // Cause is frozen once armed so a later, higher-priority request cannot re-arbitrate.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cause <= CAUSE_IRQ0;
      r_epc   <= '0;
    end else begin
      if (r_state == ST_IDLE && w_req_valid) r_cause <= w_req_cause;
      if (r_state == ST_ARM && w_armed_req && i_commit) r_epc <= i_next_pc;
    end
  end

  always_comb begin
    o_flush       = 1'b0;
    o_redirect    = 1'b0;
    o_redirect_pc = '0;
    o_in_handler  = 1'b0;
    o_ic_we       = 1'b0;
    o_ic_data     = '0;
    case (r_state)
      ST_FLUSH: begin
        o_flush   = 1'b1;
        o_ic_we   = 1'b1;
        o_ic_data = DATA_WIDTH'(w_status_clr);
      end
      ST_REDIRECT: begin
        o_redirect    = 1'b1;
        o_redirect_pc = w_vector;
      end
      ST_HANDLER:  o_in_handler = 1'b1;
      ST_RETURN: begin
        o_flush       = 1'b1;
        o_redirect    = 1'b1;
        o_redirect_pc = r_epc;
      end
      default: ;
    endcase
  end

  assign o_epc   = r_epc;
  assign o_cause = r_cause;

endmodule

// File: tb/tb_irq_sequencer.sv
// Self-checking bench for irq_sequencer: table-driven take/return vectors plus
// hand-written multi-cycle corner cases, with a strobe scoreboard.
module tb_irq_sequencer;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_status;
  logic [3:0]  i_mask;
  logic        i_ie;
  logic        i_commit;
  logic [31:0] i_next_pc;
  logic        i_eret;
  logic        o_flush;
  logic        o_redirect;
  logic [31:0] o_redirect_pc;
  logic [31:0] o_epc;
  logic [2:0]  o_cause;
  logic        o_in_handler;
  logic        o_ic_we;
  logic [31:0] o_ic_data;

  irq_sequencer #(.DATA_WIDTH(32), .VECTOR_BASE(32'h0000_0080)) dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_status      (i_status),
    .i_mask        (i_mask),
    .i_ie          (i_ie),
    .i_commit      (i_commit),
    .i_next_pc     (i_next_pc),
    .i_eret        (i_eret),
    .o_flush       (o_flush),
    .o_redirect    (o_redirect),
    .o_redirect_pc (o_redirect_pc),
    .o_epc         (o_epc),
    .o_cause       (o_cause),
    .o_in_handler  (o_in_handler),
    .o_ic_we       (o_ic_we),
    .o_ic_data     (o_ic_data)
  );

  always #5 clk = ~clk;

  // kind: 0 = FLUSH (write-back), 1 = REDIRECT to vector, 2 = RETURN
  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] epc;
    logic [2:0]  cause;
  } exp_t;

  typedef struct {
    logic [31:0] status;
    logic [3:0]  mask;
    logic        ie;
    logic [31:0] pc;
    logic        take;
    logic [2:0]  cause;
    logic [31:0] vec;
    logic [31:0] icd;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   n_total = 0;
  int   n_bad   = 0;
  logic mon_en  = 1'b0;
  int   m_kind;
  exp_t m_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input logic [31:0] a, input logic [31:0] epc,
                      input logic [2:0] cause);
    exp_t e;
    e.kind = kind; e.a = a; e.epc = epc; e.cause = cause;
    sb.push_back(e);
  endtask

  task automatic push_take(input logic [31:0] icd, input logic [31:0] vec,
                           input logic [31:0] epc, input logic [2:0] cause);
    push(0, icd, 32'h0, 3'd0);
    push(1, vec, epc, cause);
  endtask

  // Called while in HANDLER with the serviced status already cleared.
  task automatic do_return(input logic [31:0] epc);
    i_eret = 1'b1;
    push(2, epc, 32'h0, 3'd0);
    tick();
    i_eret = 1'b0;
    chk("ret_flush", {31'b0, o_flush}, 32'd1);
    chk("ret_redirect", {31'b0, o_redirect}, 32'd1);
    tick();
    chk("ret_idle", {31'b0, o_in_handler}, 32'd0);
  endtask

  // Scoreboard monitor: every strobe cycle must match the next queued event.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!o_redirect) chk("rpc_zero", o_redirect_pc, 32'h0);
      if (!o_ic_we)    chk("icd_zero", o_ic_data, 32'h0);
      if (o_flush || o_redirect || o_ic_we) begin
        m_kind = (o_flush && o_redirect) ? 2 : (o_redirect ? 1 : 0);
        if (sb.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_strobe: got flush=%b redirect=%b we=%b, required no strobe (t=%0t)",
                   o_flush, o_redirect, o_ic_we, $time);
        end else begin
          m_e = sb.pop_front();
          chk("strobe_kind", m_kind, m_e.kind);
          case (m_e.kind)
            0: begin
              chk("ic_we", {31'b0, o_ic_we}, 32'd1);
              chk("ic_data", o_ic_data, m_e.a);
            end
            1: begin
              chk("vector_pc", o_redirect_pc, m_e.a);
              chk("epc", o_epc, m_e.epc);
              chk("cause", {29'b0, o_cause}, {29'b0, m_e.cause});
            end
            default: begin
              chk("return_pc", o_redirect_pc, m_e.a);
              chk("ret_no_we", {31'b0, o_ic_we}, 32'd0);
            end
          endcase
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0400, 4'hF, 1'b1, 32'h100, 1'b1, 3'd2, 32'hA0, 32'h0000};
    vecs[1] = '{32'h0000_8300, 4'hF, 1'b1, 32'h104, 1'b1, 3'd4, 32'hC0, 32'h0300};
    vecs[2] = '{32'h0000_0100, 4'hE, 1'b1, 32'h108, 1'b0, 3'd0, 32'h0,  32'h0};
    vecs[3] = '{32'h0000_0100, 4'hF, 1'b0, 32'h10C, 1'b0, 3'd0, 32'h0,  32'h0};
    vecs[4] = '{32'h0000_8000, 4'h0, 1'b0, 32'h110, 1'b1, 3'd4, 32'hC0, 32'h0000};
    vecs[5] = '{32'h0000_0F00, 4'hF, 1'b1, 32'h114, 1'b1, 3'd3, 32'hB0, 32'h0700};
    vecs[6] = '{32'h0000_0300, 4'h1, 1'b1, 32'h118, 1'b1, 3'd0, 32'h80, 32'h0200};
    vecs[7] = '{32'hFFFF_0200, 4'hF, 1'b1, 32'h11C, 1'b1, 3'd1, 32'h90, 32'h0000};

    i_rst = 1'b1; i_status = '0; i_mask = 4'hF; i_ie = 1'b1;
    i_commit = 1'b1; i_next_pc = '0; i_eret = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;
    chk("rst_flush", {31'b0, o_flush}, 32'd0);
    chk("rst_redirect", {31'b0, o_redirect}, 32'd0);
    chk("rst_epc", o_epc, 32'h0);
    chk("rst_cause", {29'b0, o_cause}, 32'd0);
    chk("rst_handler", {31'b0, o_in_handler}, 32'd0);
    chk("rst_ic_we", {31'b0, o_ic_we}, 32'd0);
    mon_en = 1'b1;

    for (int i = 0; i < 8; i++) begin
      i_status = vecs[i].status; i_mask = vecs[i].mask; i_ie = vecs[i].ie;
      i_next_pc = vecs[i].pc; i_commit = 1'b1;
      if (vecs[i].take) push_take(vecs[i].icd, vecs[i].vec, vecs[i].pc, vecs[i].cause);
      tick();
      tick();
      chk("flush_latency", {31'b0, o_flush}, {31'b0, vecs[i].take});
      tick();
      chk("redirect_latency", {31'b0, o_redirect}, {31'b0, vecs[i].take});
      tick();
      chk("in_handler", {31'b0, o_in_handler}, {31'b0, vecs[i].take});
      i_status = '0;
      if (vecs[i].take) do_return(vecs[i].pc);
      else tick();
      $display("vector %0d: status=0x%08h mask=%h ie=%b take=%b", i, vecs[i].status,
               vecs[i].mask, vecs[i].ie, vecs[i].take);
    end

    // Boundary wait: five cycles without commit, then commit with a new PC.
    i_mask = 4'hF; i_ie = 1'b1; i_commit = 1'b0; i_next_pc = 32'h999;
    i_status = 32'h0000_0200;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("wait_no_flush", {31'b0, o_flush}, 32'd0);
    end
    i_commit = 1'b1; i_next_pc = 32'h204;
    push_take(32'h0, 32'h90, 32'h204, 3'd1);
    tick();
    chk("wait_flush", {31'b0, o_flush}, 32'd1);
    tick();
    tick();
    chk("wait_epc", o_epc, 32'h204);
    i_status = '0;
    do_return(32'h204);
    $display("boundary wait: epc=0x%08h", o_epc);

    // Withdrawal: request drops while armed, no write-back.
    i_commit = 1'b0; i_status = 32'h0000_0800;
    tick();
    i_status = '0; i_commit = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("withdraw_no_we", {31'b0, o_ic_we}, 32'd0);
    end
    $display("withdrawal: no write-back");

    // eret outside the handler is ignored.
    i_eret = 1'b1;
    tick();
    tick();
    i_eret = 1'b0;
    chk("eret_idle_no_flush", {31'b0, o_flush}, 32'd0);
    $display("stray eret: ignored");

    // Reset during REDIRECT abandons the take.
    i_status = 32'h0000_0100; i_next_pc = 32'h300;
    push_take(32'h0, 32'h80, 32'h300, 3'd0);
    tick();
    tick();
    tick();
    i_rst = 1'b1;
    tick();
    i_status = '0;
    chk("midrst_flush", {31'b0, o_flush}, 32'd0);
    chk("midrst_redirect", {31'b0, o_redirect}, 32'd0);
    chk("midrst_rpc", o_redirect_pc, 32'h0);
    chk("midrst_epc", o_epc, 32'h0);
    chk("midrst_cause", {29'b0, o_cause}, 32'd0);
    chk("midrst_handler", {31'b0, o_in_handler}, 32'd0);
    chk("midrst_ic_we", {31'b0, o_ic_we}, 32'd0);
    chk("midrst_ic_data", o_ic_data, 32'h0);
    i_rst = 1'b0;
    tick();
    tick();
    $display("reset in redirect: outputs cleared");

    // No nesting: a new request during HANDLER waits until after RETURN.
    i_status = 32'h0000_0100; i_next_pc = 32'h400;
    push_take(32'h0, 32'h80, 32'h400, 3'd0);
    tick(); tick(); tick(); tick();
    i_status = 32'h0000_8800;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("nest_in_handler", {31'b0, o_in_handler}, 32'd1);
      chk("nest_no_we", {31'b0, o_ic_we}, 32'd0);
    end
    i_eret = 1'b1;
    push(2, 32'h400, 32'h0, 3'd0);
    tick();
    i_eret = 1'b0; i_next_pc = 32'h500;
    chk("nest_ret_flush", {31'b0, o_flush}, 32'd1);
    push_take(32'h0000_0800, 32'hC0, 32'h500, 3'd4);
    tick();
    chk("nest_idle_no_we", {31'b0, o_ic_we}, 32'd0);
    tick();
    tick();
    chk("nest_late_we", {31'b0, o_ic_we}, 32'd1);
    tick();
    tick();
    chk("nest_cause", {29'b0, o_cause}, 32'd4);
    i_status = '0;
    do_return(32'h500);
    $display("no nesting: trap taken after return");

    tick();
    tick();
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
